// File: rtl/instr_prefetch_buf.sv
// Instruction prefetch queue feeding a registered decode-stage output.
// The output presents NOP with pc 0 whenever no real instruction is held.
module instr_prefetch_buf #(
  parameter int                BITS      = 32,
  parameter int                PC_BITS   = 32,
  parameter int                DEPTH     = 4,
  parameter logic [BITS-1:0]   NOP_INSTR = 32'h0000_0020,
  parameter int                CNT_LEFT  = $clog2(DEPTH+1)-1
) (
  input  logic                clk,
  input  logic                rst_,
  input  logic                fetch_valid,
  input  logic [BITS-1:0]     fetch_instr,
  input  logic [PC_BITS-1:0]  fetch_pc,
  output logic                fetch_ready,
  input  logic                flush,
  input  logic                dec_ready,
  output logic                dec_valid,
  output logic [BITS-1:0]     dec_instr,
  output logic [PC_BITS-1:0]  dec_pc,
  output logic [CNT_LEFT:0]   count,
  output logic                full,
  output logic                empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_LEFT:0] CNT_FULL = (CNT_LEFT+1)'(DEPTH);

  typedef struct packed {
    logic [PC_BITS-1:0] pc;
    logic [BITS-1:0]    instr;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic               push, advance, pop, bypass, q_push;

  // Status flags come straight off the occupancy register.
  assign full        = (count == CNT_FULL);
  assign empty       = (count == '0);
  assign fetch_ready = !full;

  assign push    = fetch_valid & fetch_ready;
  assign advance = dec_ready | !dec_valid;
  assign pop     = advance & !empty;
  assign bypass  = advance & empty & push;
  assign q_push  = push & !bypass;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      dec_valid <= 1'b0;
      dec_instr <= NOP_INSTR;
      dec_pc    <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      dec_valid <= 1'b0;
      dec_instr <= NOP_INSTR;
      dec_pc    <= '0;
    end else begin
      if (advance) begin
        if (pop) begin
          dec_valid <= 1'b1;
          dec_instr <= mem[rd_ptr].instr;
          dec_pc    <= mem[rd_ptr].pc;
          rd_ptr    <= rd_ptr + PTR_W'(1);
        end else if (bypass) begin
          dec_valid <= 1'b1;
          dec_instr <= fetch_instr;
          dec_pc    <= fetch_pc;
        end else begin
          dec_valid <= 1'b0;
          dec_instr <= NOP_INSTR;
          dec_pc    <= '0;
        end
      end
      if (q_push) wr_ptr <= wr_ptr + PTR_W'(1);
      case ({q_push, pop})
        2'b10:   count <= count + (CNT_LEFT+1)'(1);
        2'b01:   count <= count - (CNT_LEFT+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; a flush-cycle push is dropped.
  always_ff @(posedge clk) begin
    if (q_push && !flush) mem[wr_ptr] <= '{pc: fetch_pc, instr: fetch_instr};
  end

endmodule

// File: doc/instr_prefetch_buf.md
Name: instr_prefetch_buf

Overview:
Parametrised successor to the single-entry instruction register. A DEPTH-entry instruction prefetch queue, each entry carrying {PC, instruction}, feeds a registered decode-stage output that presents NOP (32'h0000_0020) whenever nothing is valid. It sits between instruction memory fetch and the decoder. It decouples fetch from decode stalls and supports a single-cycle flush on taken branch, jump or exception.

Parameters:
BITS, 32, instruction width
PC_BITS, 32, PC tag width per entry
DEPTH, 4, queue entries (power of two, >=2)
NOP_INSTR, 32'h0000_0020, bubble instruction presented when output not valid
CNT_LEFT, $clog2(DEPTH+1)-1, occupancy counter MSB (derived)

Ports:
clk  input  1  system clock
rst_  input  1  asynchronous active-low reset
fetch_valid  input  1  fetch presents an instruction this cycle
fetch_instr  input  BITS  instruction word from instruction memory
fetch_pc  input  PC_BITS  PC of fetch_instr
fetch_ready  output  1  buffer can accept (queue not full)
flush  input  1  discard all queued and output-stage instructions
dec_ready  input  1  decoder consumes current output this cycle (0 = decode stall)
dec_valid  output  1  dec_instr/dec_pc hold a real instruction
dec_instr  output  BITS  instruction to decoder; NOP_INSTR when dec_valid=0
dec_pc  output  PC_BITS  PC of dec_instr; 0 when dec_valid=0
count  output  CNT_LEFT+1  queue occupancy, output stage excluded
full  output  1  count==DEPTH
empty  output  1  count==0

Behaviour:
- Storage: circular queue (wr_ptr, rd_ptr, count) plus one output register {dec_valid, dec_instr, dec_pc}; all outputs derive from registers only (no combinational path from dec_ready or fetch_valid to any output).
- Reset (async, rst_=0): wr_ptr=rd_ptr=0, count=0, dec_valid=0, dec_instr=NOP_INSTR, dec_pc=0, so fetch_ready=1, full=0, empty=1. Queue contents are don't-care.
- fetch_ready = !full. push = fetch_valid & fetch_ready. fetch_valid while full is ignored (no overwrite, no error).
- advance = dec_ready | !dec_valid (output stage empty or being consumed).
- Priority per posedge: rst_ > flush > normal.
- flush=1: count<=0, wr_ptr<=rd_ptr<=0, dec_valid<=0, dec_instr<=NOP_INSTR, dec_pc<=0. A simultaneous push is dropped. A simultaneous dec_ready is irrelevant: the output is consumed this cycle by definition.
- Normal, advance=1:
  - count>0: output <= queue[rd_ptr], rd_ptr++, dec_valid<=1.
  - count==0 and push: bypass, output <= {fetch_pc, fetch_instr}, dec_valid<=1, queue untouched.
  - count==0 and no push: dec_valid<=0, dec_instr<=NOP_INSTR, dec_pc<=0.
- Normal, advance=0: output register holds.
- Push with no bypass: queue[wr_ptr] <= fetch data, wr_ptr++.
- count update: +1 for a queued push, -1 for a pop, unchanged when both or neither occur. Pointers wrap modulo DEPTH.
- Latency:
  - Empty buffer, idle output: fetch accepted at edge N appears on dec_* after edge N (1 cycle).
  - Queued entries leave in strict FIFO order, one per advancing cycle.
- Full with simultaneous pop: fetch_ready is 0 that cycle (registered full), so no push occurs. Count drops to DEPTH-1 and fetch_ready rises next cycle.
- Throughput: with dec_ready=1 continuously and fetch_valid=1 continuously, one instruction per cycle, count stays 0 (steady-state bypass).
- Reset asserted mid-operation: immediate return to reset values regardless of clk.

Test Plan:
- Reset/idle: rst_=0 then 1, no fetch -> dec_valid=0, dec_instr=32'h0000_0020, dec_pc=0, fetch_ready=1, empty=1, count=0.
- Bypass: dec_ready=1, push instr 32'h2008_0005 pc 32'h0000_0100 at edge N -> after N dec_valid=1, dec_instr=32'h2008_0005, dec_pc=32'h100, count stays 0.
- Fill and order: dec_ready=0, push 5 words A0..A4 back-to-back (DEPTH=4; first bypasses into output) -> after 5 edges count=4, full=1, fetch_ready=0. A 6th fetch_valid is ignored. Raise dec_ready -> dec_instr sequence A0,A1,A2,A3,A4 on consecutive cycles, then NOP with dec_valid=0, empty=1.
- Wrap-around: 3 cycles of push-with-stall then drain, repeated 4 times (pointers wrap twice) -> every instruction emerges in order, no duplicates or losses, count never exceeds 4.
- Flush: queue count=3, output valid, assert flush with simultaneous fetch_valid (pc 32'h200) -> next cycle count=0, dec_valid=0, dec_instr=NOP; pc 32'h200 never appears on dec_pc.
- Async reset mid-stream: rst_ dropped between edges with count=2 -> outputs return to reset values immediately, before the next clk edge.
